// File: rtl/tetris_pkg.sv
// Shared Tetris datapath definitions: playfield geometry, line-clear FSM states and score table.
package tetris_pkg;

    localparam int GRID_ROWS = 22;
    localparam int GRID_COLS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } lineclear_state_t;

    // Linear points unless the bonus table is selected; bonus caps at 8 beyond a tetris.
    function automatic logic [4:0] points(input logic [4:0] n, input logic bonus);
        if (!bonus) begin
            return n;
        end
        case (n)
            5'd0:    return 5'd0;
            5'd1:    return 5'd1;
            5'd2:    return 5'd3;
            5'd3:    return 5'd5;
            default: return 5'd8;
        endcase
    endfunction

endpackage

// File: rtl/lineclear_if.sv
// Start/grid/result bundle between the landed-piece grid and the line-clear engine.
interface lineclear_if #(
    parameter int ROWS    = tetris_pkg::GRID_ROWS,
    parameter int COLS    = tetris_pkg::GRID_COLS,
    parameter int SCORE_W = 8
);
    logic                       start;
    logic                       clear_score;
    logic [ROWS-1:0][COLS-1:0]  grid_in;
    logic [ROWS-1:0][COLS-1:0]  grid_out;
    logic                       busy;
    logic                       done;
    logic [4:0]                 lines_cleared;
    logic [SCORE_W-1:0]         score;

    modport master (
        output start, clear_score, grid_in,
        input  grid_out, busy, done, lines_cleared, score
    );

    modport slave (
        input  start, clear_score, grid_in,
        output grid_out, busy, done, lines_cleared, score
    );

endinterface

// File: rtl/lineclear_score.sv
// Saturating score accumulator; table chosen by LINECLEAR_BONUS_EN (linear points when undefined).
// Adds once per done pulse; clear_score overrides a coincident add.
module lineclear_score
    import tetris_pkg::*;
#(
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_score,
    input  logic               add_en,
    input  logic [4:0]         lines,
    output logic [SCORE_W-1:0] score
);

`ifdef LINECLEAR_BONUS_EN
    localparam logic BONUS = 1'b1;
`else
    localparam logic BONUS = 1'b0;
`endif

    logic [4:0]         pts;
    logic [SCORE_W+5:0] sum;
    logic [SCORE_W-1:0] sat_sum;

    assign pts     = points(lines, BONUS);
    assign sum     = {6'b0, score} + {{(SCORE_W+1){1'b0}}, pts};
    assign sat_sum = (|sum[SCORE_W+5:SCORE_W]) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score <= '0;
        end else if (clear_score) begin
            score <= '0;
        end else if (add_en) begin
            score <= sat_sum;
        end
    end

endmodule

// File: rtl/lineclear.sv
// Line-clear engine: captures the grid on start, scans bottom-up, collapses full rows; score table via LINECLEAR_BONUS_EN.
// done follows start by ROWS+2k+1 cycles for k cleared lines; start is ignored while busy, no backpressure.
module lineclear
    import tetris_pkg::*;
#(
    parameter int ROWS    = GRID_ROWS,
    parameter int COLS    = GRID_COLS,
    parameter int SCORE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    lineclear_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SCAN  = SCAN;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;
    localparam logic [4:0] PTR_TOP  = 5'(ROWS-1);

    logic [1:0]                state;
    logic [4:0]                ptr;
    logic [ROWS-1:0][COLS-1:0] grid;
    logic [ROWS-1:0][COLS-1:0] shifted;
    logic                      busy;
    logic                      done;
    logic [4:0]                lines;
    logic                      row_full;

    assign row_full = &grid[ptr];

    // Rows 1..ptr take the row above; row 0 refills empty; rows below ptr stay put.
    always_comb begin
        shifted = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (r == 0) begin
                shifted[r] = '0;
            end else if (r <= int'(ptr)) begin
                shifted[r] = grid[r-1];
            end else begin
                shifted[r] = grid[r];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            ptr   <= PTR_TOP;
            grid  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            lines <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        grid  <= bus.grid_in;
                        ptr   <= PTR_TOP;
                        lines <= '0;
                        busy  <= 1'b1;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (row_full) begin
                        state <= ST_SHIFT;
                    end else if (ptr == 5'd0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        ptr <= ptr - 5'd1;
                    end
                end
                ST_SHIFT: begin
                    grid  <= shifted;
                    lines <= lines + 5'd1;
                    state <= ST_SCAN;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    lineclear_score #(
        .SCORE_W (SCORE_W)
    ) u_score (
        .clk         (clk),
        .reset       (reset),
        .clear_score (bus.clear_score),
        .add_en      (done),
        .lines       (lines),
        .score       (bus.score)
    );

    assign bus.grid_out      = grid;
    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.lines_cleared = lines;

endmodule
